bmem_arbiter: RTL and testbench
===============================

# bmem_arbiter

Shares the single banked-memory port between the instruction cache and data cache once caches are integrated into `cpu`. It accepts one cacheline request at a time from either cache and serializes 256-bit writes into 64-bit bursts. It deserializes returned read bursts into full lines and pulses a per-port response. It sits between the two caches and the `bmem_*` port pins of `cpu`.

## Interface
- BEAT_W, 64, width of one bmem data beat
- BURST_LEN, 4, beats per cacheline; line width LINE_W = BEAT_W*BURST_LEN
- ADDR_W, 32, byte address width; request addresses are line-aligned
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous and active-low (asserted when 0)
- i_addr  in  ADDR_W  I-cache line address
- i_read  in  1  I-cache read request; held high until i_resp
- i_rdata  out  LINE_W  line returned to I-cache; valid when i_resp=1
- i_resp  out  1  one-cycle completion pulse
- d_addr  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache read request; held until d_resp
- d_write  in  1  D-cache write request; held until d_resp; never high together with d_read
- d_wdata  in  LINE_W  writeback line; stable while d_write=1
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse
- bmem_addr  out  ADDR_W  line address of the current transaction
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_W  write beat data
- bmem_ready  in  1  memory accepts the command or beat this cycle
- bmem_raddr  in  ADDR_W  address tag of the returned beat
- bmem_rdata  in  BEAT_W  returned beat
- bmem_rvalid  in  1  returned beat valid

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_BURST, DONE.
- IDLE: sample requests and register the grant, address, and (for writes) the wdata line.
  - Next state is RD_ISSUE for a read grant, WR_BURST for a write grant, or stay in IDLE if no request.
  - bmem_rvalid is ignored in IDLE.
- RD_ISSUE: drive bmem_read=1 and bmem_addr until a cycle with bmem_ready=1, then go to RD_WAIT.
- RD_WAIT: accept a beat only when bmem_rvalid=1 and bmem_raddr equals the latched address.
  - Beat k (0-based arrival order) is stored in line bits [k*BEAT_W +: BEAT_W].
  - A mismatched raddr beat is dropped without advancing the beat counter.
  - After beat BURST_LEN-1 is accepted, go to DONE.
- WR_BURST: drive bmem_write=1, bmem_addr, and bmem_wdata = line bits [k*BEAT_W +: BEAT_W].
  - k advances only on bmem_ready=1.
  - After beat BURST_LEN-1 is accepted, go to DONE.
- DONE: assert resp for the granted port for one cycle, with rdata valid for reads; d_rdata is don't-care for writes. Next state is IDLE.
- The beat counter is 2 bits wide (log2 BURST_LEN) and wraps to 0 on entry to RD_WAIT or WR_BURST.
- Arbitration: with both ports requesting in IDLE, the winner is set by the Configuration macro. A lone requester is always granted.
- Requesters drop their request in the cycle after resp, so a completed request is never re-granted.
- rdata outputs hold the last assembled line between responses.

## Timing
- Reset values: all bmem_* outputs 0, i_resp=d_resp=0, i_rdata=d_rdata=0, state IDLE, beat counter 0, last-grant=I.
- Reset asserted mid-transaction aborts it immediately; no resp is issued and beats still in flight after reset are ignored.
- Read with ready=1 and first beat L cycles after issue: resp in cycle 1+1+L+BURST_LEN-1+1 after the request is first seen in IDLE.
- Write with ready held high: bmem_write high for exactly BURST_LEN consecutive cycles starting the cycle after grant; resp the cycle after the last beat.
- Only one transaction is outstanding at any time. A request that arrives during a transaction waits in IDLE.

## Configuration
- BMEM_ARB_ROUND_ROBIN_EN defined: when both ports request, grant the port not granted last. last-grant resets to I, so the first tie goes to D.
- Undefined: fixed priority, D-cache always wins ties. The last-grant register is not present.

## Structure
- Shared package `bmem_arb_pkg` holds:
  - the state enum `bmem_arb_state_t`;
  - the port-id enum `bmem_port_t` (PORT_I, PORT_D);
  - the BEAT_W/BURST_LEN/LINE_W defaults.
- Sub-module `bmem_line_deser` holds the beat counter and line register for read assembly. Write serialization stays in the arbiter.

## Test plan
- I-read 0x00000040 alone, ready=1, beats 0x11..,0x22..,0x33..,0x44.. with raddr=0x40 → one i_resp pulse, i_rdata={0x44..,0x33..,0x22..,0x11..}; d_resp stays 0.
- D-write 0x80 with line {D3,D2,D1,D0}, ready=1 → bmem_write high 4 consecutive cycles, wdata D0,D1,D2,D3, addr 0x80 throughout, then d_resp; a following D-read of 0x80 returns the same line.
- I-read and D-read raised in the same cycle, three times back to back → with the macro: D,I,D… grants; without the macro: D served first every time.
- D-write with bmem_ready dropped for 3 cycles after beat 1 → beat 2 held on bmem_wdata those 3 cycles, burst completes with exactly 4 accepted beats.
- Read in RD_WAIT with a stray rvalid beat tagged raddr=0x100 (expected 0x40) → beat ignored, line built only from the 4 matching beats.
- rst driven to 0 after 2 read beats, then released → all outputs 0 immediately; no resp; the next I-read completes normally.

Source files
------------

// File: rtl/bmem_arb_pkg.sv
// bmem_arb_pkg: shared types and default geometry for the bmem arbiter.
package bmem_arb_pkg;

    localparam int DEF_BEAT_W    = 64;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_LINE_W    = DEF_BEAT_W * DEF_BURST_LEN;
    localparam int DEF_ADDR_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_BURST,
        DONE
    } bmem_arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } bmem_port_t;

endpackage

// File: rtl/bmem_line_deser.sv
// bmem_line_deser: assembles read beats into a cacheline in arrival order.
module bmem_line_deser
    import bmem_arb_pkg::*;
#(
    parameter int BEAT_W    = DEF_BEAT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BEAT_W-1:0] beat,
    output logic [LINE_W-1:0] line_next,
    output logic              last
);

    localparam int CNT_W = $clog2(BURST_LEN);

    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line;

    // line_next already contains the incoming beat so the final beat can be captured in one step
    always_comb begin
        line_next = line;
        line_next[cnt*BEAT_W +: BEAT_W] = beat;
    end

    assign last = cnt == CNT_W'(BURST_LEN - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            line <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt  <= cnt + 1'b1;
            line <= line_next;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the bmem port between I-cache and D-cache, one line at a time.
// BMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int BEAT_W    = DEF_BEAT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int CNT_W = $clog2(BURST_LEN);

    bmem_arb_state_t   state, state_next;
    bmem_port_t        grant, sel;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] line_next;
    logic [CNT_W-1:0]  wcnt;
    logic              d_req, any_req, sel_wr, accept, rd_last, wr_last;

    assign d_req   = d_read | d_write;
    assign any_req = i_read | d_req;
    assign sel_wr  = sel == PORT_D && d_write;
    assign accept  = state == RD_WAIT && bmem_rvalid && bmem_raddr == addr_q;
    assign wr_last = wcnt == CNT_W'(BURST_LEN - 1);

`ifdef BMEM_ARB_ROUND_ROBIN_EN
    bmem_port_t last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= PORT_I;
        else if (state == IDLE && any_req)
            last_grant <= sel;
    end

    assign sel = (i_read && d_req) ? (last_grant == PORT_I ? PORT_D : PORT_I)
                                   : (d_req ? PORT_D : PORT_I);
`else
    assign sel = d_req ? PORT_D : PORT_I;
`endif

    bmem_line_deser #(
        .BEAT_W   (BEAT_W),
        .BURST_LEN(BURST_LEN),
        .LINE_W   (LINE_W)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != RD_WAIT),
        .accept   (accept),
        .beat     (bmem_rdata),
        .line_next(line_next),
        .last     (rd_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = any_req ? (sel_wr ? WR_BURST : RD_ISSUE) : IDLE;
            RD_ISSUE: state_next = bmem_ready ? RD_WAIT : RD_ISSUE;
            RD_WAIT:  state_next = (accept && rd_last) ? DONE : RD_WAIT;
            WR_BURST: state_next = (bmem_ready && wr_last) ? DONE : WR_BURST;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bmem_read  = state == RD_ISSUE;
        bmem_write = state == WR_BURST;
        bmem_addr  = (state == RD_ISSUE || state == RD_WAIT || state == WR_BURST) ? addr_q : '0;
        bmem_wdata = state == WR_BURST ? wline[wcnt*BEAT_W +: BEAT_W] : '0;
        i_resp     = state == DONE && grant == PORT_I;
        d_resp     = state == DONE && grant == PORT_D;
    end

    // rdata registers load on the final beat so the line is already valid during DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant   <= PORT_I;
            addr_q  <= '0;
            wline   <= '0;
            wcnt    <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant  <= sel;
                addr_q <= sel == PORT_D ? d_addr : i_addr;
            end
            if (state == IDLE && sel_wr)
                wline <= d_wdata;
            wcnt <= state != WR_BURST ? '0 : wcnt + CNT_W'(bmem_ready);
            if (accept && rd_last && grant == PORT_I)
                i_rdata <= line_next;
            if (accept && rd_last && grant == PORT_D)
                d_rdata <= line_next;
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: directed table-driven bench for bmem_arbiter with a small line memory model.
module tb_bmem_arbiter;

    localparam logic [255:0] L40 = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] LW  = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
                                    64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
    localparam logic [255:0] LX  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                    64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A};
    localparam logic [255:0] LS  = {64'hCAFE000000000003, 64'hCAFE000000000002,
                                    64'hCAFE000000000001, 64'hCAFE000000000000};

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } vec_t;

    logic         clk = 0;
    logic         rst;
    logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
    logic         i_read, i_resp, d_read, d_write, d_resp;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    logic [255:0] mem [logic [31:0]];
    int n_tests = 0;
    int n_fail  = 0;

    bmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_read     (i_read),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_addr     (d_addr),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_bmem_read"}, bmem_read, 0);
        chk({name, "_bmem_write"}, bmem_write, 0);
        chk({name, "_bmem_addr"}, bmem_addr, 0);
        chk({name, "_bmem_wdata"}, bmem_wdata, 0);
        chk({name, "_resp"}, {i_resp, d_resp}, 0);
        chk({name, "_i_rdata"}, i_rdata, 0);
        chk({name, "_d_rdata"}, d_rdata, 0);
    endtask

    // Caller has raised the request; serves the read from mem and checks the response.
    task automatic complete_read(input bit is_d, input logic [31:0] addr, input int lat,
                                 input bit stray, input logic [255:0] exp);
        int n;
        logic [255:0] src;
        src = mem.exists(addr) ? mem[addr] : '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bmem_read && n < 20);
        chk("rd_issue_seen", bmem_read, 1);
        chk("rd_addr", bmem_addr, addr);
        @(negedge clk);
        repeat (lat - 1) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (stray && k == 2) begin
                bmem_rvalid = 1;
                bmem_raddr  = 32'h100;
                bmem_rdata  = 64'hBADBADBADBADBAD0;
                @(negedge clk);
            end
            bmem_rvalid = 1;
            bmem_raddr  = addr;
            bmem_rdata  = src[k*64 +: 64];
            @(negedge clk);
        end
        bmem_rvalid = 0;
        chk("rd_resp", is_d ? d_resp : i_resp, 1);
        chk("rd_other_resp", is_d ? i_resp : d_resp, 0);
        chk("rd_line", is_d ? d_rdata : i_rdata, exp);
        i_read = 0;
        d_read = 0;
        @(negedge clk);
        chk("rd_resp_pulse", {i_resp, d_resp}, 0);
        chk("rd_line_held", is_d ? d_rdata : i_rdata, exp);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input bit stall);
        int cyc, acc, stl, first;
        logic [255:0] cap;
        cyc = 0; acc = 0; stl = 0; first = -1; cap = '0;
        d_addr  = addr;
        d_wdata = line;
        d_write = 1;
        while (acc < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (bmem_write) begin
                if (first < 0)
                    first = cyc;
                chk("wr_addr", bmem_addr, addr);
                chk("wr_beat", bmem_wdata, line[acc*64 +: 64]);
                if (stall && acc == 2 && stl < 3) begin
                    bmem_ready = 0;
                    stl++;
                end else begin
                    bmem_ready = 1;
                    cap[acc*64 +: 64] = bmem_wdata;
                    acc++;
                end
            end else if (first >= 0) begin
                chk("wr_contiguous", bmem_write, 1);
            end
        end
        bmem_ready = 1;
        chk("wr_beats_accepted", acc, 4);
        chk("wr_first_cycle", first, 1);
        chk("wr_write_cycles", cyc - first + 1, stall ? 7 : 4);
        @(negedge clk);
        chk("wr_d_resp", d_resp, 1);
        chk("wr_i_resp", i_resp, 0);
        chk("wr_write_low", bmem_write, 0);
        d_write = 0;
        mem[addr] = cap;
        @(negedge clk);
        chk("wr_resp_pulse", d_resp, 0);
    endtask

    initial begin
        vec_t vecs[7];
        logic [2:0] tie_d;
        vecs[0] = '{is_d: 0, wr: 0, addr: 32'h40, line: L40};
        vecs[1] = '{is_d: 1, wr: 1, addr: 32'h80, line: LW};
        vecs[2] = '{is_d: 1, wr: 0, addr: 32'h80, line: LW};
        vecs[3] = '{is_d: 0, wr: 0, addr: 32'h80, line: LW};
        vecs[4] = '{is_d: 1, wr: 0, addr: 32'h40, line: L40};
        vecs[5] = '{is_d: 1, wr: 1, addr: 32'hC0, line: LX};
        vecs[6] = '{is_d: 0, wr: 0, addr: 32'hC0, line: LX};
`ifdef BMEM_ARB_ROUND_ROBIN_EN
        tie_d = 3'b101;
`else
        tie_d = 3'b111;
`endif
        mem[32'h40] = L40;
        rst = 0;
        i_addr = 0; i_read = 0;
        d_addr = 0; d_read = 0; d_write = 0; d_wdata = 0;
        bmem_ready = 1; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].line, 0);
            end else begin
                if (vecs[i].is_d) begin
                    d_addr = vecs[i].addr;
                    d_read = 1;
                end else begin
                    i_addr = vecs[i].addr;
                    i_read = 1;
                end
                complete_read(vecs[i].is_d, vecs[i].addr, (i % 3) + 1, 0, vecs[i].line);
            end
        end

        // stray beat with a foreign address tag
        i_addr = 32'h40;
        i_read = 1;
        complete_read(0, 32'h40, 2, 1, L40);

        // write with bmem_ready dropped after beat 1, then read it back
        do_write(32'h100, LS, 1);
        d_addr = 32'h100;
        d_read = 1;
        complete_read(1, 32'h100, 1, 0, LS);

        // simultaneous I/D reads, from a fresh reset so last-grant starts at I
        rst = 0;
        @(negedge clk);
        rst = 1;
        for (int r = 0; r < 3; r++) begin
            i_addr = 32'h40;
            d_addr = 32'h80;
            i_read = 1;
            d_read = 1;
            complete_read(tie_d[r], tie_d[r] ? 32'h80 : 32'h40, 1, 0, tie_d[r] ? LW : L40);
        end

        // reset mid-read after two beats, remaining beats arrive while idle
        i_addr = 32'h40;
        i_read = 1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bmem_read && n < 20);
            chk("mid_rst_issue", bmem_read, 1);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1;
            bmem_raddr  = 32'h40;
            bmem_rdata  = L40[k*64 +: 64];
            @(negedge clk);
        end
        rst = 0;
        #1;
        chk_idle_outputs("mid_rst");
        i_read = 0;
        @(negedge clk);
        rst = 1;
        for (int k = 2; k < 4; k++) begin
            bmem_rvalid = 1;
            bmem_raddr  = 32'h40;
            bmem_rdata  = L40[k*64 +: 64];
            @(negedge clk);
            chk("post_rst_no_resp", {i_resp, d_resp}, 0);
            chk("post_rst_no_read", bmem_read, 0);
        end
        bmem_rvalid = 0;
        @(negedge clk);
        chk("post_rst_rdata", i_rdata, 0);
        i_addr = 32'h40;
        i_read = 1;
        complete_read(0, 32'h40, 3, 0, L40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
